// File: rtl/epcs_pkg.sv
// rtl/epcs_pkg.sv - shared state encoding and command opcodes for the EPCS responder
//
// Contents:
//   epcs_state_t  - responder frame state
//   CMD_*         - serial flash opcodes understood by the responder
//   status_byte() - status register image built from the write-enable latch

package epcs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        STATUS,
        SID_DUMMY,
        SID,
        IGNORE
    } epcs_state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_RDSID = 8'hAB;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_WRDI  = 8'h04;

    // Address and dummy phases are both 24 bits long.
    localparam logic [4:0] ADDR_BIT_LAST = 5'd23;

    // WIP is never set because nothing is ever programmed.
    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b000000, wel, 1'b0};
    endfunction

endpackage

// File: rtl/epcs_sync_edge.sv
// rtl/epcs_sync_edge.sv - two-flop synchronizer with registered edge strobes
//
// Ports:
//   i_clk    - system clock
//   i_rst    - synchronous active-high reset
//   i_async  - pin from the foreign clock domain
//   o_level  - synchronized level, aligned with the strobes
//   o_rise   - one-cycle strobe, 3 cycles after a pin rising edge
//   o_fall   - one-cycle strobe, 3 cycles after a pin falling edge

module epcs_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // The strobes are registered so that they line up with r_prev; the
    // level seen by the consumer is therefore consistent with the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/epcs_responder.sv
// rtl/epcs_responder.sv - serial flash (EPCS) read-only responder backed by a byte memory
//
// Ports:
//   clk_clk           - system clock, >= 8x dclk
//   reset_reset       - synchronous active-high reset
//   flash_as_dclk     - serial clock from the master (asynchronous)
//   flash_as_sce      - chip select, active-low
//   flash_as_sdo      - master-out data, MSB first
//   flash_as_data0    - responder-out data, MSB first
//   mem_address       - backing memory byte address
//   mem_read          - one-cycle read request
//   mem_readdata      - backing memory read data
//   mem_readdatavalid - read data valid
//   underrun          - sticky: a read byte was not ready at its first fall strobe

module epcs_responder
    import epcs_pkg::*;
#(
    parameter int          ADDR_W     = 24,
    parameter logic [7:0]  SILICON_ID = 8'h16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              flash_as_dclk,
    input  logic              flash_as_sce,
    input  logic              flash_as_sdo,
    output logic              flash_as_data0,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [7:0]        mem_readdata,
    input  logic              mem_readdatavalid,
    output logic              underrun
);

    logic w_dclk_level, w_dclk_rise, w_dclk_fall;
    logic w_sce_level,  w_sce_rise,  w_sce_fall;
    logic w_sdo,        w_sdo_rise,  w_sdo_fall;

    epcs_sync_edge #(.RESET_VAL(1'b0)) u_sync_dclk (
        .i_clk(clk_clk), .i_rst(reset_reset), .i_async(flash_as_dclk),
        .o_level(w_dclk_level), .o_rise(w_dclk_rise), .o_fall(w_dclk_fall)
    );

    epcs_sync_edge #(.RESET_VAL(1'b1)) u_sync_sce (
        .i_clk(clk_clk), .i_rst(reset_reset), .i_async(flash_as_sce),
        .o_level(w_sce_level), .o_rise(w_sce_rise), .o_fall(w_sce_fall)
    );

    epcs_sync_edge #(.RESET_VAL(1'b0)) u_sync_sdo (
        .i_clk(clk_clk), .i_rst(reset_reset), .i_async(flash_as_sdo),
        .o_level(w_sdo), .o_rise(w_sdo_rise), .o_fall(w_sdo_fall)
    );

    logic w_unused;
    assign w_unused = ^{w_dclk_level, w_sce_rise, w_sdo_rise, w_sdo_fall};

    epcs_state_t       r_state,       w_state_nxt;
    logic [2:0]        r_bit_cnt,     w_bit_cnt_nxt;
    logic [4:0]        r_addr_cnt,    w_addr_cnt_nxt;
    logic [6:0]        r_cmd_sr,      w_cmd_sr_nxt;
    logic [22:0]       r_addr_sr,     w_addr_sr_nxt;
    logic [7:0]        r_out_sr,      w_out_sr_nxt;
    logic              r_data0,       w_data0_nxt;
    logic              r_wel,         w_wel_nxt;
    logic              r_underrun,    w_underrun_nxt;
    logic [ADDR_W-1:0] r_mem_address, w_mem_address_nxt;
    logic              r_mem_read,    w_mem_read_nxt;
    logic              r_pending,     w_pending_nxt;   // a read is outstanding
    logic              r_discard,     w_discard_nxt;   // outstanding read is stale
    logic              r_req,         w_req_nxt;       // read wanted, waiting for the bus
    logic              r_have,        w_have_nxt;      // r_buf holds the next byte
    logic [7:0]        r_buf,         w_buf_nxt;

    logic [7:0]  w_cmd;
    logic [23:0] w_addr_full;
    logic [7:0]  w_byte;
    logic        w_need_read;

    assign w_cmd       = {r_cmd_sr, w_sdo};
    assign w_addr_full = {r_addr_sr, w_sdo};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= 3'd0;
            r_addr_cnt    <= 5'd0;
            r_cmd_sr      <= 7'd0;
            r_addr_sr     <= 23'd0;
            r_out_sr      <= 8'd0;
            r_data0       <= 1'b0;
            r_wel         <= 1'b0;
            r_underrun    <= 1'b0;
            r_mem_address <= '0;
            r_mem_read    <= 1'b0;
            r_pending     <= 1'b0;
            r_discard     <= 1'b0;
            r_req         <= 1'b0;
            r_have        <= 1'b0;
            r_buf         <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_addr_cnt    <= w_addr_cnt_nxt;
            r_cmd_sr      <= w_cmd_sr_nxt;
            r_addr_sr     <= w_addr_sr_nxt;
            r_out_sr      <= w_out_sr_nxt;
            r_data0       <= w_data0_nxt;
            r_wel         <= w_wel_nxt;
            r_underrun    <= w_underrun_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_pending     <= w_pending_nxt;
            r_discard     <= w_discard_nxt;
            r_req         <= w_req_nxt;
            r_have        <= w_have_nxt;
            r_buf         <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_addr_cnt_nxt    = r_addr_cnt;
        w_cmd_sr_nxt      = r_cmd_sr;
        w_addr_sr_nxt     = r_addr_sr;
        w_out_sr_nxt      = r_out_sr;
        w_data0_nxt       = r_data0;
        w_wel_nxt         = r_wel;
        w_underrun_nxt    = r_underrun;
        w_mem_address_nxt = r_mem_address;
        w_mem_read_nxt    = 1'b0;
        w_pending_nxt     = r_pending;
        w_discard_nxt     = r_discard;
        w_req_nxt         = r_req;
        w_have_nxt        = r_have;
        w_buf_nxt         = r_buf;
        w_byte            = 8'h00;
        w_need_read       = 1'b0;

        // Read return; valid with nothing outstanding is ignored.
        if (r_pending && mem_readdatavalid) begin
            w_pending_nxt = 1'b0;
            w_discard_nxt = 1'b0;
            if (!r_discard) begin
                w_have_nxt = 1'b1;
                w_buf_nxt  = mem_readdata;
            end
        end

        if (w_sce_level) begin
            w_state_nxt    = IDLE;
            w_bit_cnt_nxt  = 3'd0;
            w_addr_cnt_nxt = 5'd0;
            w_data0_nxt    = 1'b0;
            w_have_nxt     = 1'b0;
            w_req_nxt      = 1'b0;
            // A read still in flight belongs to the aborted frame.
            w_discard_nxt  = w_pending_nxt;
        end else if (w_sce_fall) begin
            w_state_nxt    = CMD;
            w_bit_cnt_nxt  = 3'd0;
            w_addr_cnt_nxt = 5'd0;
            w_data0_nxt    = 1'b0;
        end else begin
            case (r_state)
                CMD: begin
                    if (w_dclk_rise) begin
                        w_cmd_sr_nxt  = w_cmd[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_addr_cnt_nxt = 5'd0;
                            case (w_cmd)
                                CMD_READ:  w_state_nxt = ADDR;
                                CMD_RDSR:  w_state_nxt = STATUS;
                                CMD_RDSID: w_state_nxt = SID_DUMMY;
                                CMD_WREN: begin
                                    w_wel_nxt   = 1'b1;
                                    w_state_nxt = IGNORE;
                                end
                                CMD_WRDI: begin
                                    w_wel_nxt   = 1'b0;
                                    w_state_nxt = IGNORE;
                                end
                                default:   w_state_nxt = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (w_dclk_rise) begin
                        w_addr_sr_nxt  = w_addr_full[22:0];
                        w_addr_cnt_nxt = r_addr_cnt + 5'd1;
                        if (r_addr_cnt == ADDR_BIT_LAST) begin
                            w_state_nxt       = READ;
                            w_mem_address_nxt = w_addr_full[ADDR_W-1:0];
                            w_need_read       = 1'b1;
                        end
                    end
                end
                SID_DUMMY: begin
                    if (w_dclk_rise) begin
                        w_addr_cnt_nxt = r_addr_cnt + 5'd1;
                        if (r_addr_cnt == ADDR_BIT_LAST) begin
                            w_state_nxt = SID;
                        end
                    end
                end
                default: ;
            endcase

            // Output phase: bit counter counts fall strobes; a new byte is
            // loaded whenever it wraps to zero and its MSB goes out at once.
            if (w_dclk_fall) begin
                if (r_state == READ || r_state == STATUS || r_state == SID) begin
                    if (r_bit_cnt == 3'd0) begin
                        if (r_state == READ) begin
                            if (r_have) begin
                                w_byte     = r_buf;
                                w_have_nxt = 1'b0;
                            end else if (r_pending && mem_readdatavalid && !r_discard) begin
                                w_byte     = mem_readdata;
                                w_have_nxt = 1'b0;
                            end else begin
                                w_byte         = 8'h00;
                                w_underrun_nxt = 1'b1;
                                // The late byte must not slide into the next slot.
                                w_discard_nxt  = w_pending_nxt;
                            end
                            w_mem_address_nxt = r_mem_address + ADDR_W'(1);
                            w_need_read       = 1'b1;
                        end else if (r_state == STATUS) begin
                            w_byte = status_byte(r_wel);
                        end else begin
                            w_byte = SILICON_ID;
                        end
                        w_data0_nxt  = w_byte[7];
                        w_out_sr_nxt = {w_byte[6:0], 1'b0};
                    end else begin
                        w_data0_nxt  = r_out_sr[7];
                        w_out_sr_nxt = {r_out_sr[6:0], 1'b0};
                    end
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                end else begin
                    w_data0_nxt = 1'b0;
                end
            end
        end

        // Single outstanding read: hold the request until the bus is free.
        if (w_need_read || (r_req && !w_sce_level)) begin
            if (!w_pending_nxt) begin
                w_mem_read_nxt = 1'b1;
                w_pending_nxt  = 1'b1;
                w_req_nxt      = 1'b0;
            end else begin
                w_req_nxt = 1'b1;
            end
        end
    end

    assign flash_as_data0 = r_data0;
    assign mem_address    = r_mem_address;
    assign mem_read       = r_mem_read;
    assign underrun       = r_underrun;

endmodule

// File: tb/tb_epcs_responder.sv
// tb/tb_epcs_responder.sv - scoreboard bench for epcs_responder (24-bit and 8-bit address builds)

module tb_epcs_responder;
    import epcs_pkg::*;

    localparam int H = 8;  // clk cycles per dclk half period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dclk = 1'b0;
    logic sce = 1'b1;
    logic sdo = 1'b0;

    always #5 clk = ~clk;

    logic        data0_a, mem_read_a, rdv_a, underrun_a;
    logic [23:0] addr_a;
    logic [7:0]  rdata_a = 8'h00;
    logic        data0_b, mem_read_b, rdv_b, underrun_b;
    logic [7:0]  addr_b;
    logic [7:0]  rdata_b = 8'h00;

    epcs_responder #(.ADDR_W(24), .SILICON_ID(8'h16)) dut_a (
        .clk_clk(clk), .reset_reset(rst),
        .flash_as_dclk(dclk), .flash_as_sce(sce), .flash_as_sdo(sdo),
        .flash_as_data0(data0_a),
        .mem_address(addr_a), .mem_read(mem_read_a),
        .mem_readdata(rdata_a), .mem_readdatavalid(rdv_a),
        .underrun(underrun_a)
    );

    epcs_responder #(.ADDR_W(8), .SILICON_ID(8'h16)) dut_b (
        .clk_clk(clk), .reset_reset(rst),
        .flash_as_dclk(dclk), .flash_as_sce(sce), .flash_as_sdo(sdo),
        .flash_as_data0(data0_b),
        .mem_address(addr_b), .mem_read(mem_read_b),
        .mem_readdata(rdata_b), .mem_readdatavalid(rdv_b),
        .underrun(underrun_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_img [256];
    int          lat = 2;
    bit          withhold = 1'b0;

    logic [7:0]  exp_bytes [$];
    logic [7:0]  rx_a [$];
    logic [7:0]  rx_b [$];
    logic [23:0] exp_addr_a [$];
    logic [7:0]  exp_addr_b [$];
    event        rx_ev;

    logic        m_wel = 1'b0;
    logic        m_underrun = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory models: a read returns its byte lat cycles after mem_read.
    int         cnt_a = 0, cnt_b = 0;
    logic [7:0] idx_a = 8'h00, idx_b = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            cnt_a <= 0;
            rdv_a <= 1'b0;
        end else begin
            rdv_a <= 1'b0;
            if (mem_read_a) begin
                cnt_a <= lat - 1;
                idx_a <= addr_a[7:0];
            end else if (cnt_a > 0) begin
                cnt_a <= cnt_a - 1;
                if (cnt_a == 1 && !withhold) begin
                    rdv_a   <= 1'b1;
                    rdata_a <= mem_img[idx_a];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cnt_b <= 0;
            rdv_b <= 1'b0;
        end else begin
            rdv_b <= 1'b0;
            if (mem_read_b) begin
                cnt_b <= lat - 1;
                idx_b <= addr_b;
            end else if (cnt_b > 0) begin
                cnt_b <= cnt_b - 1;
                if (cnt_b == 1 && !withhold) begin
                    rdv_b   <= 1'b1;
                    rdata_b <= mem_img[idx_b];
                end
            end
        end
    end

    // Read-address monitors.
    always @(negedge clk) begin
        if (!rst && mem_read_a) begin
            if (exp_addr_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mem_read_a: unexpected read of %0h, expected none", addr_a);
            end else begin
                check("mem_address_a", {8'h00, addr_a}, {8'h00, exp_addr_a.pop_front()});
            end
        end
        if (!rst && mem_read_b) begin
            if (exp_addr_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mem_read_b: unexpected read of %0h, expected none", addr_b);
            end else begin
                check("mem_address_b", {24'h0, addr_b}, {24'h0, exp_addr_b.pop_front()});
            end
        end
    end

    // data0 byte monitor.
    initial begin
        logic [7:0] e;
        forever begin
            @(rx_ev);
            while (rx_a.size() > 0) begin
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL data0: unexpected byte %0h, expected none", rx_a[0]);
                    e = 8'h00;
                end else begin
                    e = exp_bytes.pop_front();
                    check("data0_a", {24'h0, rx_a[0]}, {24'h0, e});
                    check("data0_b", {24'h0, rx_b[0]}, {24'h0, e});
                end
                void'(rx_a.pop_front());
                void'(rx_b.pop_front());
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: set sdo, raise dclk and sample data0, lower dclk.
    task automatic xbits(input logic [7:0] tx, input int nb, input bit capture);
        logic [7:0] ga, gb;
        ga = 8'h00;
        gb = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            sdo = tx[i];
            clk_wait(H);
            dclk = 1'b1;
            ga[i] = data0_a;
            gb[i] = data0_b;
            clk_wait(H);
            dclk = 1'b0;
        end
        if (capture) begin
            rx_a.push_back(ga);
            rx_b.push_back(gb);
            -> rx_ev;
        end
    endtask

    task automatic frame_end();
        clk_wait(H);
        sce = 1'b1;
        clk_wait(2 * H);
    endtask

    task automatic do_status(input int n);
        sce = 1'b0;
        xbits(CMD_RDSR, 8, 1'b0);
        for (int k = 0; k < n; k++) begin
            exp_bytes.push_back(m_wel ? 8'h02 : 8'h00);
            xbits(8'($urandom), 8, 1'b1);
        end
        frame_end();
    endtask

    task automatic do_sid(input int n);
        sce = 1'b0;
        xbits(CMD_RDSID, 8, 1'b0);
        for (int k = 0; k < 3; k++) xbits(8'($urandom), 8, 1'b0);
        for (int k = 0; k < n; k++) begin
            exp_bytes.push_back(8'h16);
            xbits(8'($urandom), 8, 1'b1);
        end
        frame_end();
    endtask

    // Any command that produces no data: data0 must stay low.
    task automatic do_simple(input logic [7:0] c);
        if (c == CMD_WREN) m_wel = 1'b1;
        if (c == CMD_WRDI) m_wel = 1'b0;
        sce = 1'b0;
        xbits(c, 8, 1'b0);
        exp_bytes.push_back(8'h00);
        xbits(8'($urandom), 8, 1'b1);
        frame_end();
    endtask

    // n data bytes: every byte boundary, including the one after the last
    // byte, fetches the following address.
    task automatic do_read(input logic [23:0] a, input int n);
        logic [7:0] ix;
        for (int k = 0; k <= n + 1; k++) begin
            if (k == 0 || !withhold) begin
                exp_addr_a.push_back(a + 24'(k));
                exp_addr_b.push_back(a[7:0] + 8'(k));
            end
        end
        for (int k = 0; k < n; k++) begin
            ix = a[7:0] + 8'(k);
            exp_bytes.push_back(withhold ? 8'h00 : mem_img[ix]);
        end
        if (withhold) m_underrun = 1'b1;
        sce = 1'b0;
        xbits(CMD_READ, 8, 1'b0);
        xbits(a[23:16], 8, 1'b0);
        xbits(a[15:8], 8, 1'b0);
        xbits(a[7:0], 8, 1'b0);
        for (int k = 0; k < n; k++) xbits(8'($urandom), 8, 1'b1);
        frame_end();
    endtask

    task automatic check_underrun(input string name);
        check({name, "_a"}, {31'h0, underrun_a}, {31'h0, m_underrun});
        check({name, "_b"}, {31'h0, underrun_b}, {31'h0, m_underrun});
    endtask

    initial begin
        logic [7:0]  c;
        logic [23:0] a;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
        mem_img[8'h10] = 8'hA5;
        mem_img[8'h11] = 8'h3C;

        clk_wait(5);
        rst = 1'b0;
        clk_wait(1);
        check("reset_state", 32'(dut_a.r_state), 32'(IDLE));
        check("reset_data0", {31'h0, data0_a}, 32'h0);
        check("reset_mem_read", {31'h0, mem_read_a}, 32'h0);
        check("reset_mem_address", {8'h0, addr_a}, 32'h0);
        check_underrun("reset_underrun");
        clk_wait(2 * H);

        // Status, write enable, status again.
        do_status(1);
        do_simple(CMD_WREN);
        do_status(2);
        do_simple(CMD_WRDI);
        do_status(1);

        // Silicon ID.
        do_sid(2);

        // Directed reads, including the 8-bit address wrap.
        lat = 2;
        do_read(24'h000010, 2);
        check_underrun("read_underrun");
        do_read(24'h0000FF, 2);
        do_read(24'hFFFFFE, 3);

        // Abort after 13 address bits.
        sce = 1'b0;
        xbits(CMD_READ, 8, 1'b0);
        xbits(8'h00, 8, 1'b0);
        xbits(8'h5A, 5, 1'b0);
        clk_wait(H);
        sce = 1'b1;
        clk_wait(6);
        check("abort_state", 32'(dut_a.r_state), 32'(IDLE));
        check("abort_addr_cnt", 32'(dut_a.r_addr_cnt), 32'h0);
        check("abort_bit_cnt", 32'(dut_a.r_bit_cnt), 32'h0);
        check("abort_data0", {31'h0, data0_a}, 32'h0);
        clk_wait(2 * H);
        do_status(1);

        // Randomized frames.
        for (int it = 0; it < 24; it++) begin
            lat = $urandom_range(2, 4);
            case ($urandom_range(0, 5))
                0: do_status($urandom_range(1, 2));
                1: do_sid($urandom_range(1, 2));
                2: do_simple(CMD_WREN);
                3: do_simple(CMD_WRDI);
                4: begin
                    do begin
                        c = 8'($urandom);
                    end while (c == CMD_READ || c == CMD_RDSR || c == CMD_RDSID ||
                               c == CMD_WREN || c == CMD_WRDI);
                    do_simple(c);
                end
                default: begin
                    a = 24'($urandom);
                    do_read(a, $urandom_range(1, 3));
                    check_underrun("rand_underrun");
                end
            endcase
        end

        // Memory withholding data: zeros and a sticky underrun.
        withhold = 1'b1;
        do_read(24'h000020, 2);
        check_underrun("withhold_underrun");
        do_status(1);
        check_underrun("sticky_underrun");
        clk_wait(2);
        rst = 1'b1;
        withhold = 1'b0;
        clk_wait(4);
        rst = 1'b0;
        m_wel = 1'b0;
        m_underrun = 1'b0;
        clk_wait(2);
        check_underrun("underrun_after_reset");
        clk_wait(2 * H);
        do_status(1);
        lat = 3;
        do_read(24'h000040, 1);
        check_underrun("final_underrun");

        clk_wait(20);
        check("exp_bytes_left", 32'(exp_bytes.size()), 32'h0);
        check("exp_addr_a_left", 32'(exp_addr_a.size()), 32'h0);
        check("exp_addr_b_left", 32'(exp_addr_b.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
